// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and helpers for the mux8_rr_arbiter slice.
package mux8_arb_pkg;

  localparam int N_REQ_DEF = 8;
  localparam int SEL_W_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Binary index of the single set bit; returns 0 for an all-zero vector.
  function automatic logic [SEL_W_DEF-1:0] onehot2bin(input logic [N_REQ_DEF-1:0] oh);
    logic [SEL_W_DEF-1:0] b;
    b = '0;
    for (int i = 0; i < N_REQ_DEF; i++) begin
      if (oh[i]) b = b | SEL_W_DEF'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant/data bundle between the requester lanes and the shared mux arbiter.
interface mux8_rr_arbiter_if #(
  parameter int N_REQ = 8,
  parameter int SEL_W = 3
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] din;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             gnt_valid;
  logic             dout;
  logic             dout_valid;

  modport master (
    output req, din,
    input  gnt, sel, gnt_valid, dout, dout_valid
  );

  modport slave (
    input  req, din,
    output gnt, sel, gnt_valid, dout, dout_valid
  );
endinterface

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Round-robin winner search: first set bit of req&mask, starting just after 'last'.
module rr_pick
  import mux8_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] last,
  output logic             win_vld,
  output logic [SEL_W-1:0] win_idx
);

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] win_oh;
  logic [SEL_W-1:0] idx;
  logic             found;

  // Walk last+1, last+2, ... wrapping; N_REQ is a power of two so the index wraps naturally.
  always_comb begin
    cand   = req & mask;
    win_oh = '0;
    found  = 1'b0;
    idx    = last;
    for (int k = 0; k < N_REQ; k++) begin
      idx = idx + SEL_W'(1);
      if (!found && cand[idx]) begin
        win_oh[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign win_vld = found;
  assign win_idx = SEL_W'(onehot2bin(N_REQ_DEF'(win_oh)));

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one N_REQ:1 serial mux; registered grant, select and data.
// Optional forced rotation after MAX_HOLD grant cycles: define ARB_TIMEOUT_EN.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mux8_rr_arbiter_if.slave  bus
);

  if (SEL_W != $clog2(N_REQ) || N_REQ < 2 || N_REQ > 8) begin : g_bad_width
    $error("mux8_rr_arbiter: N_REQ must be a power of two in 2..8 with SEL_W == clog2(N_REQ)");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("mux8_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             gv_q, gv_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             dout_q, dv_q;

  logic [N_REQ-1:0] pick_mask;
  logic             win_vld;
  logic [SEL_W-1:0] win_idx;
  logic [N_REQ-1:0] win_oh;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]       hold_q, hold_d;
`endif

  // In IDLE everyone is eligible; on release/rotation the current holder is masked out.
  assign pick_mask = (state_q == IDLE) ? '1 : ~gnt_q;
  assign win_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (bus.req),
    .mask    (pick_mask),
    .last    (last_q),
    .win_vld (win_vld),
    .win_idx (win_idx)
  );

  // Next-state and next-grant decision.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    gv_d    = gv_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = win_oh;
          sel_d   = win_idx;
          gv_d    = 1'b1;
          last_d  = win_idx;
`ifdef ARB_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (bus.req[sel_q]) begin
`ifdef ARB_TIMEOUT_EN
          if (hold_q == 8'(MAX_HOLD - 1)) begin
            // win_vld here means another requester is waiting
            if (win_vld) begin
              gnt_d  = win_oh;
              sel_d  = win_idx;
              last_d = win_idx;
            end
            hold_d = 8'd0;
          end else if (hold_q != 8'hFF) begin
            hold_d = hold_q + 8'd1;
          end
`endif
        end else if (win_vld) begin
          gnt_d  = win_oh;
          sel_d  = win_idx;
          last_d = win_idx;
`ifdef ARB_TIMEOUT_EN
          hold_d = 8'd0;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          gv_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        gv_d    = 1'b0;
      end
    endcase
  end

  // Control registers; last resets to N_REQ-1 so the first search starts at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      gv_q    <= 1'b0;
      last_q  <= SEL_W'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      hold_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      gv_q    <= gv_d;
      last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  // Registered mux output, one cycle behind sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
      dv_q   <= 1'b0;
    end else begin
      dout_q <= gv_q ? bus.din[sel_q] : 1'b0;
      dv_q   <= gv_q;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.sel        = sel_q;
  assign bus.gnt_valid  = gv_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed testbench for mux8_rr_arbiter.
module tb_mux8_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [7:0] din_v;

  mux8_rr_arbiter_if #(.N_REQ(8), .SEL_W(3)) bus ();

  mux8_rr_arbiter #(
    .N_REQ    (8),
    .SEL_W    (3),
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 8'h00;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.din = 8'h00;
    do_reset();
    n_checks++;
    if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL reset_gnt got=%h exp=00", bus.gnt); end
    n_checks++;
    if (bus.sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
    n_checks++;
    if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gv got=%b exp=0", bus.gnt_valid); end
    n_checks++;
    if (bus.dout !== 1'b0 || bus.dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_dout got=%b/%b exp=0/0", bus.dout, bus.dout_valid);
    end
  endtask

  task automatic test_single();
    bus.din = 8'h01;
    bus.req = 8'h01;
    step();
    n_checks++;
    if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.gnt_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_grant got gnt=%h sel=%0d gv=%b exp 01/0/1", bus.gnt, bus.sel, bus.gnt_valid);
    end
    n_checks++;
    if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL single_dv_c1 got=%b exp=0", bus.dout_valid); end
    step();
    n_checks++;
    if (bus.dout !== 1'b1 || bus.dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_data got=%b/%b exp=1/1", bus.dout, bus.dout_valid);
    end
    bus.req = 8'h00;
    step();
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.sel !== 3'd0) begin
      n_fail++; $display("FAIL single_release got gnt=%h gv=%b sel=%0d exp 00/0/0", bus.gnt, bus.gnt_valid, bus.sel);
    end
    step();
    n_checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== 1'b0) begin
      n_fail++; $display("FAIL single_dout_idle got=%b/%b exp=0/0", bus.dout, bus.dout_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] prev;
    do_reset();
    din_v   = 8'hA5;
    bus.din = din_v;
    bus.req = 8'hFF;
    step();
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (bus.sel !== 3'(k) || bus.gnt !== (8'h01 << k) || bus.gnt_valid !== 1'b1) begin
        n_fail++; $display("FAIL rr_first k=%0d got sel=%0d gnt=%h exp sel=%0d", k, bus.sel, bus.gnt, k);
      end
      prev    = bus.sel;
      bus.req = 8'hFF;
      step();
      n_checks++;
      if (bus.sel !== 3'(k) || !$onehot(bus.gnt)) begin
        n_fail++; $display("FAIL rr_hold k=%0d got sel=%0d gnt=%h exp sel=%0d", k, bus.sel, bus.gnt, k);
      end
      n_checks++;
      if (bus.dout !== din_v[prev] || bus.dout_valid !== 1'b1) begin
        n_fail++; $display("FAIL rr_data k=%0d got=%b exp=%b", k, bus.dout, din_v[prev]);
      end
      bus.req = 8'hFF & ~(8'h01 << k);
      step();
      bus.req = 8'hFF;
    end
    n_checks++;
    if (bus.sel !== 3'd0 || bus.gnt !== 8'h01 || bus.gnt_valid !== 1'b1) begin
      n_fail++; $display("FAIL rr_wrap got sel=%0d gnt=%h exp 0/01", bus.sel, bus.gnt);
    end
    bus.req = 8'h00;
    step();
  endtask

  task automatic test_wrap_search();
    do_reset();
    bus.req = 8'h08;
    step();
    n_checks++;
    if (bus.sel !== 3'd3) begin n_fail++; $display("FAIL wrap_start got=%0d exp=3", bus.sel); end
    bus.req = 8'h85;
    step();
    n_checks++;
    if (bus.sel !== 3'd7 || bus.gnt !== 8'h80) begin
      n_fail++; $display("FAIL wrap_to7 got sel=%0d gnt=%h exp 7/80", bus.sel, bus.gnt);
    end
    bus.req = 8'h05;
    step();
    n_checks++;
    if (bus.sel !== 3'd0 || bus.gnt !== 8'h01) begin
      n_fail++; $display("FAIL wrap_to0 got sel=%0d gnt=%h exp 0/01", bus.sel, bus.gnt);
    end
    bus.req = 8'h04;
    step();
    n_checks++;
    if (bus.sel !== 3'd2 || bus.gnt !== 8'h04 || bus.gnt_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_to2 got sel=%0d gnt=%h exp 2/04", bus.sel, bus.gnt);
    end
    bus.req = 8'h00;
    step();
    n_checks++;
    if (bus.gnt_valid !== 1'b0 || bus.sel !== 3'd2) begin
      n_fail++; $display("FAIL wrap_idle got gv=%b sel=%0d exp 0/2", bus.gnt_valid, bus.sel);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.din = 8'hFF;
    bus.req = 8'h20;
    step();
    step();
    n_checks++;
    if (bus.sel !== 3'd5 || bus.dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup got sel=%0d dv=%b exp 5/1", bus.sel, bus.dout_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.sel !== 3'd0 || bus.gnt_valid !== 1'b0 ||
        bus.dout !== 1'b0 || bus.dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_clear got gnt=%h sel=%0d gv=%b dout=%b dv=%b exp all 0",
                         bus.gnt, bus.sel, bus.gnt_valid, bus.dout, bus.dout_valid);
    end
    bus.req = 8'h24;
    #1;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (bus.sel !== 3'd2 || bus.gnt !== 8'h04 || bus.gnt_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_rearb got sel=%0d gnt=%h exp 2/04", bus.sel, bus.gnt);
    end
    bus.req = 8'h00;
    step();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [2:0] exp_sel;
    do_reset();
    bus.req = 8'h03;
    for (int c = 1; c <= 16; c++) begin
      step();
      exp_sel = (((c - 1) / 4) % 2 == 0) ? 3'd0 : 3'd1;
      n_checks++;
      if (bus.sel !== exp_sel || bus.gnt !== (8'h01 << exp_sel)) begin
        n_fail++; $display("FAIL timeout_rot c=%0d got sel=%0d exp=%0d", c, bus.sel, exp_sel);
      end
    end
    bus.req = 8'h01;
    for (int c = 0; c < 20; c++) begin
      step();
      n_checks++;
      if (bus.sel !== 3'd0 || bus.gnt_valid !== 1'b1) begin
        n_fail++; $display("FAIL timeout_alone c=%0d got sel=%0d gv=%b exp 0/1", c, bus.sel, bus.gnt_valid);
      end
    end
    bus.req = 8'h00;
    step();
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    bus.req = 8'h03;
    for (int c = 0; c < 100; c++) begin
      step();
      n_checks++;
      if (bus.sel !== 3'd0 || bus.gnt !== 8'h01) begin
        n_fail++; $display("FAIL no_timeout c=%0d got sel=%0d gnt=%h exp 0/01", c, bus.sel, bus.gnt);
      end
    end
    bus.req = 8'h00;
    step();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.din  = 8'h00;
    din_v    = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_search();
    test_reset_mid_grant();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
